// File: rtl/prbs_engine.sv
// Parametrised Fibonacci-LFSR PRBS generator/checker with lock tracking and error counting.
// Optional macro PRBS_ERR_INJECT_EN adds an 'inject' input that flips single generated bits.
module prbs_engine #(
    parameter int unsigned      WIDTH      = 7,
    parameter logic [WIDTH-1:0] TAPS       = 7'h60,
    parameter int unsigned      LOCK_CNT   = 16,
    parameter int unsigned      UNLOCK_CNT = 4,
    parameter int unsigned      CNT_W      = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] seed,
    input  logic             enable,
    input  logic             mode,
    input  logic             rx_bit,
`ifdef PRBS_ERR_INJECT_EN
    input  logic             inject,
`endif
    output logic             tx_bit,
    output logic [WIDTH-1:0] state_out,
    output logic             locked,
    output logic             err_pulse,
    output logic [CNT_W-1:0] err_count
);

    localparam int unsigned FILL_W  = $clog2(WIDTH + 1);
    localparam int unsigned MATCH_W = $clog2(LOCK_CNT + 1);
    localparam int unsigned MISS_W  = $clog2(UNLOCK_CNT + 1);

    typedef enum logic [1:0] {HUNT, SYNC, LOCKED} fsm_e;

    fsm_e               fsm_q, fsm_d;
    logic [WIDTH-1:0]   lfsr_q, lfsr_d;
    logic               tx_q, tx_d;
    logic [FILL_W-1:0]  fill_q, fill_d;
    logic [MATCH_W-1:0] match_q, match_d;
    logic [MISS_W-1:0]  miss_q, miss_d;
    logic [CNT_W-1:0]   err_cnt_q, err_cnt_d;
    logic               err_pulse_q, err_pulse_d;
    logic               locked_q, locked_d;
    logic               mode_q;
    logic               fb_c;
    logic               in_bit_c;
    logic               step_c;
    logic               inj_c;

`ifdef PRBS_ERR_INJECT_EN
    assign inj_c = inject;
`else
    assign inj_c = 1'b0;
`endif

    assign fb_c = ^(lfsr_q & TAPS);

    // State register
    always_ff @(posedge clock) begin
        if (!reset) begin
            fsm_q       <= HUNT;
            lfsr_q      <= '1;
            tx_q        <= 1'b1;
            fill_q      <= '0;
            match_q     <= '0;
            miss_q      <= '0;
            err_cnt_q   <= '0;
            err_pulse_q <= 1'b0;
            locked_q    <= 1'b0;
            mode_q      <= 1'b0;
        end else begin
            fsm_q       <= fsm_d;
            lfsr_q      <= lfsr_d;
            tx_q        <= tx_d;
            fill_q      <= fill_d;
            match_q     <= match_d;
            miss_q      <= miss_d;
            err_cnt_q   <= err_cnt_d;
            err_pulse_q <= err_pulse_d;
            locked_q    <= locked_d;
            mode_q      <= mode;
        end
    end

    // Next state: load > mode change > enabled step
    always_comb begin
        fsm_d       = fsm_q;
        lfsr_d      = lfsr_q;
        tx_d        = tx_q;
        fill_d      = fill_q;
        match_d     = match_q;
        miss_d      = miss_q;
        err_cnt_d   = err_cnt_q;
        err_pulse_d = 1'b0;
        in_bit_c    = fb_c;
        step_c      = 1'b0;

        if (load) begin
            lfsr_d    = (seed == '0) ? '1 : seed;
            tx_d      = lfsr_d[WIDTH-1];
            fsm_d     = HUNT;
            fill_d    = '0;
            match_d   = '0;
            miss_d    = '0;
            err_cnt_d = '0;
        end else if (mode != mode_q) begin
            fsm_d   = HUNT;
            fill_d  = '0;
            match_d = '0;
            miss_d  = '0;
        end else if (enable) begin
            step_c = 1'b1;
            if (!mode) begin
                fsm_d   = HUNT;
                fill_d  = '0;
                match_d = '0;
                miss_d  = '0;
            end else begin
                case (fsm_q)
                    HUNT: begin
                        in_bit_c = rx_bit;
                        if (fill_q == FILL_W'(WIDTH - 1)) begin
                            fsm_d   = SYNC;
                            fill_d  = '0;
                            match_d = '0;
                        end else begin
                            fill_d = fill_q + FILL_W'(1);
                        end
                    end
                    SYNC: begin
                        in_bit_c = rx_bit;
                        if (rx_bit == fb_c) begin
                            if (match_q == MATCH_W'(LOCK_CNT - 1)) begin
                                fsm_d   = LOCKED;
                                match_d = '0;
                                miss_d  = '0;
                            end else begin
                                match_d = match_q + MATCH_W'(1);
                            end
                        end else begin
                            fsm_d   = HUNT;
                            fill_d  = '0;
                            match_d = '0;
                        end
                    end
                    LOCKED: begin
                        // Free-run on the prediction; received bits only score errors
                        in_bit_c = fb_c;
                        if (rx_bit != fb_c) begin
                            err_pulse_d = 1'b1;
                            if (err_cnt_q != '1) begin
                                err_cnt_d = err_cnt_q + CNT_W'(1);
                            end
                            if (miss_q == MISS_W'(UNLOCK_CNT - 1)) begin
                                fsm_d   = HUNT;
                                fill_d  = '0;
                                match_d = '0;
                                miss_d  = '0;
                            end else begin
                                miss_d = miss_q + MISS_W'(1);
                            end
                        end else begin
                            miss_d = '0;
                        end
                    end
                    default: fsm_d = HUNT;
                endcase
            end
            lfsr_d = {lfsr_q[WIDTH-2:0], in_bit_c};
            tx_d   = lfsr_d[WIDTH-1] ^ (inj_c & ~mode);
        end

        locked_d = (fsm_d == LOCKED);
    end

    assign tx_bit    = tx_q;
    assign state_out = lfsr_q;
    assign locked    = locked_q;
    assign err_pulse = err_pulse_q;
    assign err_count = err_cnt_q;

endmodule

// File: tb/tb_prbs_engine.sv
// Directed bench: generator feeding two checkers (16-bit and 2-bit error counters).
module tb_prbs_engine;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       load = 1'b0;
    logic [6:0] seed = 7'h00;
    logic       en = 1'b0;
    logic       inv = 1'b0;
    logic       inject = 1'b0;

    logic       g_tx, g_lock, g_ep, c_tx, c_lock, c_ep, s_tx, s_lock, s_ep;
    logic [6:0] g_st, c_st, s_st;
    logic [15:0] g_ec, c_ec;
    logic [1:0] s_ec;

    int total = 0;
    int bad = 0;

    always #5 clock = ~clock;

    prbs_engine g (
        .clock(clock), .reset(reset), .load(load), .seed(seed), .enable(en),
        .mode(1'b0), .rx_bit(1'b0),
`ifdef PRBS_ERR_INJECT_EN
        .inject(inject),
`endif
        .tx_bit(g_tx), .state_out(g_st), .locked(g_lock), .err_pulse(g_ep), .err_count(g_ec)
    );

    prbs_engine c (
        .clock(clock), .reset(reset), .load(load), .seed(seed), .enable(en),
        .mode(1'b1), .rx_bit(g_tx),
`ifdef PRBS_ERR_INJECT_EN
        .inject(1'b0),
`endif
        .tx_bit(c_tx), .state_out(c_st), .locked(c_lock), .err_pulse(c_ep), .err_count(c_ec)
    );

    prbs_engine #(.CNT_W(2)) s (
        .clock(clock), .reset(reset), .load(load), .seed(seed), .enable(en),
        .mode(1'b1), .rx_bit(g_tx ^ inv),
`ifdef PRBS_ERR_INJECT_EN
        .inject(1'b0),
`endif
        .tx_bit(s_tx), .state_out(s_st), .locked(s_lock), .err_pulse(s_ep), .err_count(s_ec)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_load(input logic [6:0] v, input logic with_en);
        seed = v;
        load = 1'b1;
        en   = with_en;
        tick();
        load = 1'b0;
    endtask

    initial begin
        int first_ret;
        int lat;
        int pulses;

        // Reset values
        reset = 1'b0;
        tick();
        tick();
        chk("rst_state", 32'(g_st), 32'h7F);
        chk("rst_tx", 32'(g_tx), 32'h1);
        chk("rst_locked", 32'(c_lock), 32'h0);
        chk("rst_err_count", 32'(c_ec), 32'h0);
        chk("rst_err_pulse", 32'(c_ep), 32'h0);
        reset = 1'b1;

        // Zero seed falls back to all-ones
        do_load(7'h00, 1'b0);
        chk("seed0_state", 32'(g_st), 32'h7F);
        chk("seed0_locked", 32'(c_lock), 32'h0);
        chk("seed0_err", 32'(c_ec), 32'h0);

        // Period from seed 1
        do_load(7'h01, 1'b0);
        chk("seed1_state", 32'(g_st), 32'h01);
        chk("seed1_tx", 32'(g_tx), 32'h0);
        en = 1'b1;
        first_ret = 0;
        for (int i = 1; i <= 130; i++) begin
            tick();
            if (i == 1) chk("step1", 32'(g_st), 32'h02);
            if (i == 6) chk("step6", 32'(g_st), 32'h41);
            if (g_st == 7'h01 && first_ret == 0) first_ret = i;
        end
        chk("period", 32'(first_ret), 32'd127);

        // Load with enable: seed taken without shifting, then lock latency
        do_load(7'h5A, 1'b1);
        chk("load_noshift", 32'(g_st), 32'h5A);
        chk("load_unlocked", 32'(c_lock), 32'h0);
        lat = 0;
        for (int i = 1; i <= 60; i++) begin
            tick();
            if (c_lock) begin
                lat = i;
                break;
            end
        end
        chk("lock_latency", 32'(lat), 32'd23);

        // Clean stream for 1000 cycles
        pulses = 0;
        for (int i = 0; i < 1000; i++) begin
            tick();
            if (c_ep) pulses++;
        end
        chk("clean_pulses", 32'(pulses), 32'd0);
        chk("clean_err", 32'(c_ec), 32'd0);
        chk("clean_locked", 32'(c_lock), 32'h1);

        // Random enable gaps keep lock
        for (int i = 0; i < 500; i++) begin
            en = 1'($urandom_range(0, 1));
            tick();
            if (c_ep) pulses++;
        end
        en = 1'b1;
        chk("gap_pulses", 32'(pulses), 32'd0);
        chk("gap_locked", 32'(c_lock), 32'h1);
        chk("gap_err", 32'(c_ec), 32'd0);

`ifdef PRBS_ERR_INJECT_EN
        // Single injected bit: one error, lock held
        inject = 1'b1;
        tick();
        inject = 1'b0;
        pulses = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (c_ep) pulses++;
        end
        chk("inj1_pulses", 32'(pulses), 32'd1);
        chk("inj1_err", 32'(c_ec), 32'd1);
        chk("inj1_locked", 32'(c_lock), 32'h1);

        // Four consecutive bad bits drop lock, then relock
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            inject = 1'b1;
            tick();
            if (c_ep) pulses++;
        end
        inject = 1'b0;
        lat = -1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (c_ep) pulses++;
            if (!c_lock) begin
                lat = 0;
                break;
            end
        end
        chk("inj4_unlock", 32'(lat), 32'd0);
        lat = 0;
        for (int i = 1; i <= 60; i++) begin
            tick();
            if (c_ep) pulses++;
            if (c_lock) begin
                lat = i;
                break;
            end
        end
        chk("inj4_relock_ok", 32'((lat >= 1) && (lat <= 23)), 32'h1);
        chk("inj4_pulses", 32'(pulses), 32'd4);
        chk("inj4_err", 32'(c_ec), 32'd5);
`endif

        // Reload clears counters; saturation on the 2-bit checker
        do_load(7'h33, 1'b1);
        chk("reload_err", 32'(c_ec), 32'd0);
        for (int i = 0; i < 30; i++) tick();
        chk("sat_prelock", 32'(s_lock), 32'h1);
        chk("sat_pre_err", 32'(s_ec), 32'd0);
        inv = 1'b1;
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (s_ep) pulses++;
            if (i == 1) chk("sat_err_after2", 32'(s_ec), 32'd2);
        end
        chk("sat_pulses", 32'(pulses), 32'd4);
        chk("sat_err", 32'(s_ec), 32'd3);
        chk("sat_unlocked", 32'(s_lock), 32'h0);
        chk("sat_c_locked", 32'(c_lock), 32'h1);
        inv = 1'b0;

        // Reset while locked
        reset = 1'b0;
        tick();
        chk("rst_lock_drop", 32'(c_lock), 32'h0);
        chk("rst_lock_state", 32'(g_st), 32'h7F);
        reset = 1'b1;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
